// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule permutation tables, shift schedule and state type
package des_pkg;

   // Entries are 1-based DES bit numbers; bit 1 is the MSB of the source vector.
   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Bit r-1 set means round r rotates by one bit (rounds 1, 2, 9, 16).
   localparam logic [15:0] SHIFT_ONE = 16'h8103;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - PC-2 compression permutation, rotated C||D (56 bits) to one 48-bit subkey
module des_pc2
   import des_pkg::*;
(
   input  logic [55:0] i_cd,
   output logic [47:0] o_subkey
);

   always_comb begin
      o_subkey = '0;
      for (int j = 0; j < 48; j++) begin
         o_subkey[47-j] = i_cd[6'(56 - PC2_TBL[j])];
      end
   end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES key schedule, one subkey per cycle into a 16x48 bank
module des_key_schedule
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   input  logic        key_valid,
   output logic        key_ready,
   output logic        busy,
   output logic        subkeys_valid,
   output logic [47:0] K1,
   output logic [47:0] K2,
   output logic [47:0] K3,
   output logic [47:0] K4,
   output logic [47:0] K5,
   output logic [47:0] K6,
   output logic [47:0] K7,
   output logic [47:0] K8,
   output logic [47:0] K9,
   output logic [47:0] K10,
   output logic [47:0] K11,
   output logic [47:0] K12,
   output logic [47:0] K13,
   output logic [47:0] K14,
   output logic [47:0] K15,
   output logic [47:0] K16
);

   state_t      r_state;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_rnd;
   logic        r_mode;
   logic        r_valid;
   logic [47:0] r_bank [16];

   logic [55:0] w_pc1;
   logic        w_single;
   logic [27:0] w_c_rot;
   logic [27:0] w_d_rot;
   logic [47:0] w_subkey;
   logic [3:0]  w_slot;

   // Parity bits never appear in PC-1, so they drop out here.
   always_comb begin
      w_pc1 = '0;
      for (int i = 0; i < 56; i++) begin
         w_pc1[55-i] = key_in[6'(64 - PC1_TBL[i])];
      end
   end

   assign w_single = SHIFT_ONE[r_rnd];
   assign w_c_rot  = w_single ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
   assign w_d_rot  = w_single ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};

   // Decrypt mode fills the bank back to front so the Feistel wiring is reused unchanged.
   assign w_slot   = r_mode ? (4'd15 - r_rnd) : r_rnd;

   des_pc2 u_pc2 (
      .i_cd     ({w_c_rot, w_d_rot}),
      .o_subkey (w_subkey)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_rnd   <= '0;
         r_mode  <= 1'b0;
         r_valid <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_bank[i] <= '0;
         end
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (key_valid) begin
                  r_c     <= w_pc1[55:28];
                  r_d     <= w_pc1[27:0];
                  r_mode  <= decrypt;
                  r_rnd   <= '0;
                  r_valid <= 1'b0;
                  r_state <= GEN;
               end
            end
            GEN: begin
               r_bank[w_slot] <= w_subkey;
               r_c            <= w_c_rot;
               r_d            <= w_d_rot;
               r_rnd          <= r_rnd + 4'd1;
               if (r_rnd == 4'd15) begin
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign key_ready     = (r_state != GEN);
   assign busy          = (r_state == GEN);
   assign subkeys_valid = r_valid;

   assign K1  = r_bank[0];
   assign K2  = r_bank[1];
   assign K3  = r_bank[2];
   assign K4  = r_bank[3];
   assign K5  = r_bank[4];
   assign K6  = r_bank[5];
   assign K7  = r_bank[6];
   assign K8  = r_bank[7];
   assign K9  = r_bank[8];
   assign K10 = r_bank[9];
   assign K11 = r_bank[10];
   assign K12 = r_bank[11];
   assign K13 = r_bank[12];
   assign K14 = r_bank[13];
   assign K15 = r_bank[14];
   assign K16 = r_bank[15];

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - scoreboard bench for des_key_schedule with a DES reference model
module tb_des_key_schedule;

   localparam int PC1_M [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_M [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
   };
   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
   };
   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };
   // Entry (row*16+col) is the nibble at that position, first nibble leftmost.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAEB17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;
   localparam logic [63:0] TPT  = 64'h0123456789ABCDEF;

   typedef struct {
      logic [767:0] set;
      int           acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] key_in;
   logic        decrypt;
   logic        key_valid;
   logic        key_ready;
   logic        busy;
   logic        subkeys_valid;
   logic [47:0] k_out [16];

   exp_t sb_q [$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   last_acc = 0;
   logic prev_valid = 1'b0;

   des_key_schedule dut (
      .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .key_valid(key_valid),
      .key_ready(key_ready), .busy(busy), .subkeys_valid(subkeys_valid),
      .K1(k_out[0]),   .K2(k_out[1]),   .K3(k_out[2]),   .K4(k_out[3]),
      .K5(k_out[4]),   .K6(k_out[5]),   .K7(k_out[6]),   .K8(k_out[7]),
      .K9(k_out[8]),   .K10(k_out[9]),  .K11(k_out[10]), .K12(k_out[11]),
      .K13(k_out[12]), .K14(k_out[13]), .K15(k_out[14]), .K16(k_out[15])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [47:0] slot(input logic [767:0] s, input int i);
      return s[767-48*i -: 48];
   endfunction

   // Subkeys from the textbook rules: PC-1, cumulative left rotation of each half, PC-2.
   function automatic logic [767:0] model_set(input logic [63:0] key, input bit dec);
      logic [55:0]  cd0;
      logic [55:0]  cdr;
      logic [47:0]  k;
      logic [767:0] s;
      int           shift;
      int           idx;
      s = '0;
      for (int i = 1; i <= 56; i++) cd0[56-i] = key[64-PC1_M[i-1]];
      shift = 0;
      for (int r = 1; r <= 16; r++) begin
         shift += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
         for (int i = 1; i <= 28; i++) begin
            idx = ((i - 1 + shift) % 28) + 1;
            cdr[56-i] = cd0[56-idx];
            cdr[28-i] = cd0[28-idx];
         end
         for (int j = 1; j <= 48; j++) k[48-j] = cdr[56-PC2_M[j-1]];
         idx = dec ? (16 - r) : (r - 1);
         s[767-48*idx -: 48] = k;
      end
      return s;
   endfunction

   function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
      logic [255:0] t;
      int           idx;
      t   = SBOX[n];
      idx = int'({b[5], b[0]}) * 16 + int'(b[4:1]);
      return t[255-4*idx -: 4];
   endfunction

   // Full DES block operation; a reversed subkey set turns it into decryption.
   function automatic logic [63:0] des_crypt(input logic [63:0] x, input logic [767:0] ks);
      logic [63:0] ip_o;
      logic [63:0] pre;
      logic [63:0] y;
      logic [31:0] l, r, t, f, s_o;
      logic [47:0] e;
      for (int j = 1; j <= 64; j++) ip_o[64-j] = x[64-IP_T[j-1]];
      l = ip_o[63:32];
      r = ip_o[31:0];
      for (int rd = 0; rd < 16; rd++) begin
         for (int j = 1; j <= 48; j++) e[48-j] = r[32-E_T[j-1]];
         e = e ^ slot(ks, rd);
         for (int s = 0; s < 8; s++) s_o[31-4*s -: 4] = sbox(s, e[47-6*s -: 6]);
         for (int j = 1; j <= 32; j++) f[32-j] = s_o[32-P_T[j-1]];
         t = l ^ f;
         l = r;
         r = t;
      end
      pre = {r, l};
      for (int j = 1; j <= 64; j++) y[64-IP_T[j-1]] = pre[64-j];
      return y;
   endfunction

   // Caller is just past a negedge or a posedge; returns #1 after the accepting edge.
   task automatic start_key(input logic [63:0] k, input bit dec);
      exp_t e;
      int   n;
      key_in    = k;
      decrypt   = dec;
      key_valid = 1'b1;
      n = 0;
      while (!key_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!key_ready) chk("accept_timeout", 64'(key_ready), 64'd1);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      decrypt   = ~dec;
      key_in    = {$urandom, $urandom};
      e.set     = model_set(k, dec);
      e.acc     = cyc;
      last_acc  = cyc;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(output logic [767:0] s);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!subkeys_valid && n < 40);
      if (!subkeys_valid) chk("done_timeout", 64'(subkeys_valid), 64'd1);
      for (int i = 0; i < 16; i++) s[767-48*i -: 48] = k_out[i];
   endtask

   task automatic run_key(input logic [63:0] k, input bit dec, output logic [767:0] s);
      @(negedge clk);
      start_key(k, dec);
      wait_done(s);
   endtask

   // Monitor: every rising subkeys_valid retires the oldest expected set.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (subkeys_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               for (int i = 0; i < 16; i++)
                  chk($sformatf("sb_K%0d", i + 1), 64'(k_out[i]), 64'(slot(e.set, i)));
               chk("latency", 64'(cyc - e.acc), 64'd16);
            end
         end
         prev_valid = subkeys_valid;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [767:0] se, sd, s;
      logic [63:0]  ct, pt, k, kb;
      exp_t         dropped;
      int           acc_a;

      rst = 1'b1; key_valid = 1'b0; key_in = '0; decrypt = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_key_ready", 64'(key_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(subkeys_valid), 64'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("rst_K%0d", i + 1), 64'(k_out[i]), 64'd0);

      run_key(TKEY, 1'b0, se);
      chk("known_enc_K1", 64'(slot(se, 0)), 64'h1B02EFFC7072);
      chk("known_enc_K16", 64'(slot(se, 15)), 64'hCB3D8B0E17F5);
      ct = des_crypt(TPT, se);
      chk("known_cipher", ct, 64'h85E813540F0AB405);

      run_key(TKEY, 1'b1, sd);
      chk("known_dec_K1", 64'(slot(sd, 0)), 64'hCB3D8B0E17F5);
      chk("known_dec_K16", 64'(slot(sd, 15)), 64'h1B02EFFC7072);
      chk("known_plain", des_crypt(ct, sd), TPT);

      run_key(64'h0, 1'b0, s);
      for (int i = 0; i < 16; i++) chk($sformatf("zero_K%0d", i + 1), 64'(slot(s, i)), 64'd0);
      run_key(64'h0101010101010101, 1'b0, s);
      for (int i = 0; i < 16; i++) chk($sformatf("parity_K%0d", i + 1), 64'(slot(s, i)), 64'd0);

      // Second key held valid through GEN must wait for the first DONE cycle.
      k  = {$urandom, $urandom};
      kb = {$urandom, $urandom};
      @(negedge clk);
      start_key(k, 1'b0);
      acc_a = last_acc;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         key_in = kb; decrypt = 1'b0; key_valid = 1'b1;
         chk("gen_key_ready", 64'(key_ready), 64'd0);
         chk("gen_busy", 64'(busy), 64'd1);
      end
      @(negedge clk);
      chk("done_key_ready", 64'(key_ready), 64'd1);
      chk("done_valid", 64'(subkeys_valid), 64'd1);
      start_key(kb, 1'b0);
      chk("b2b_accept_cycle", 64'(last_acc - acc_a), 64'd17);
      wait_done(s);

      // Reset with rnd = 7 discards the partial set.
      @(negedge clk);
      start_key(k, 1'b1);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      dropped = sb_q.pop_back();
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_valid", 64'(subkeys_valid), 64'd0);
      chk("midrst_key_ready", 64'(key_ready), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("midrst_K%0d", i + 1), 64'(k_out[i]), 64'd0);
      run_key({$urandom, $urandom}, 1'b1, s);

      for (int n = 0; n < 200; n++) begin
         k  = {$urandom, $urandom};
         pt = {$urandom, $urandom};
         run_key(k, 1'b0, se);
         run_key(k, 1'b1, sd);
         chk($sformatf("roundtrip_%0d", n), des_crypt(des_crypt(pt, se), sd), pt);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
